// File: rtl/bs_drvr_fifo.sv
// bs_drvr_fifo: bus driver with independent TX (device -> bus) and RX
// (bus -> device) first-word-fall-through FIFOs, with sticky overflow flags.
//
// Ports
//   clk, reset            single clock, asynchronous active-high reset
//   wr_en, D_in           device write into TX
//   full, pndng, D_pop    TX status / head to the bus arbiter
//   pop                   arbiter consumes TX head
//   push, D_push          bus delivery into RX (never back-pressured)
//   rx_pndng, D_out       RX status / head to the device
//   rd_en                 device consumes RX head
//   tx_cnt, rx_cnt        occupancy of each FIFO
//   tx_ovf, rx_ovf        sticky drop flags, cleared by ovf_clr

// One circular buffer with count, FWFT head and sticky overflow flag.
module bs_drvr_fifo_buf #(
   parameter int unsigned PCKG  = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr,
   input  logic [PCKG-1:0] din,
   input  logic            rd,
   input  logic            clr,
   output logic [PCKG-1:0] dout,
   output logic [CW-1:0]   cnt,
   output logic            ovf
);

   logic [PCKG-1:0] mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic            ovf_q, ovf_nxt;
   logic            full_c, empty_c, rd_ok, wr_ok;

   // Accept/drop decisions and next-state computation.
   always_comb begin
      full_c     = (cnt_q == CW'(DEPTH));
      empty_c    = (cnt_q == '0);
      rd_ok      = rd && !empty_c;
      // A pop on a full FIFO frees the slot the write needs this cycle.
      wr_ok      = wr && (!full_c || rd_ok);
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      ovf_nxt    = ovf_q;
      if (rd_ok)
         rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (wr_ok)
         wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      cnt_nxt = cnt_q + CW'(wr_ok) - CW'(rd_ok);
      // A drop in the clearing cycle wins so the event is not lost.
      if (clr)
         ovf_nxt = 1'b0;
      if (wr && !wr_ok)
         ovf_nxt = 1'b1;
   end

   // Pointer, count and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
         cnt_q  <= cnt_nxt;
         ovf_q  <= ovf_nxt;
      end
   end

   // Storage; contents are not reset, occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset)
         mem[wr_ptr] <= din;
   end

   assign dout = (cnt_q != '0) ? mem[rd_ptr] : '0;
   assign cnt  = cnt_q;
   assign ovf  = ovf_q;

endmodule

module bs_drvr_fifo #(
   parameter int unsigned PCKG  = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [PCKG-1:0] D_in,
   output logic            full,
   output logic            pndng,
   output logic [PCKG-1:0] D_pop,
   input  logic            pop,
   input  logic            push,
   input  logic [PCKG-1:0] D_push,
   output logic            rx_pndng,
   output logic [PCKG-1:0] D_out,
   input  logic            rd_en,
   output logic [CW-1:0]   tx_cnt,
   output logic [CW-1:0]   rx_cnt,
   output logic            tx_ovf,
   output logic            rx_ovf,
   input  logic            ovf_clr
);

   // Device -> bus queue.
   bs_drvr_fifo_buf #(.PCKG(PCKG), .DEPTH(DEPTH)) u_tx (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en),
      .din   (D_in),
      .rd    (pop),
      .clr   (ovf_clr),
      .dout  (D_pop),
      .cnt   (tx_cnt),
      .ovf   (tx_ovf)
   );

   // Bus -> device queue; its full state only causes drops.
   bs_drvr_fifo_buf #(.PCKG(PCKG), .DEPTH(DEPTH)) u_rx (
      .clk   (clk),
      .reset (reset),
      .wr    (push),
      .din   (D_push),
      .rd    (rd_en),
      .clr   (ovf_clr),
      .dout  (D_out),
      .cnt   (rx_cnt),
      .ovf   (rx_ovf)
   );

   // Flags come from registered counts only.
   assign pndng    = (tx_cnt != '0);
   assign full     = (tx_cnt == CW'(DEPTH));
   assign rx_pndng = (rx_cnt != '0);

endmodule

// File: tb/tb_bs_drvr_fifo.sv
// Self-checking bench for bs_drvr_fifo: directed TX vector table, hand-written
// RX / reset sequences, and a randomized run against a queue reference model.
module tb_bs_drvr_fifo;

   localparam int unsigned PCKG  = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic            wr_en, pop, push, rd_en, ovf_clr;
   logic [PCKG-1:0] D_in, D_push, D_pop, D_out;
   logic            full, pndng, rx_pndng, tx_ovf, rx_ovf;
   logic [CW-1:0]   tx_cnt, rx_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bs_drvr_fifo #(.PCKG(PCKG), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .D_in     (D_in),
      .full     (full),
      .pndng    (pndng),
      .D_pop    (D_pop),
      .pop      (pop),
      .push     (push),
      .D_push   (D_push),
      .rx_pndng (rx_pndng),
      .D_out    (D_out),
      .rd_en    (rd_en),
      .tx_cnt   (tx_cnt),
      .rx_cnt   (rx_cnt),
      .tx_ovf   (tx_ovf),
      .rx_ovf   (rx_ovf),
      .ovf_clr  (ovf_clr)
   );

   typedef struct {
      logic            wr;
      logic [PCKG-1:0] din;
      logic            pop;
      logic            clr;
      logic [CW-1:0]   e_cnt;
      logic            e_pnd;
      logic            e_full;
      logic [PCKG-1:0] e_dpop;
      logic            e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(int wr, int din, int p, int clr,
                               int cnt, int pnd, int fl, int dpop, int ovf);
      vec_t v;
      v.wr     = 1'(wr);
      v.din    = PCKG'(din);
      v.pop    = 1'(p);
      v.clr    = 1'(clr);
      v.e_cnt  = CW'(cnt);
      v.e_pnd  = 1'(pnd);
      v.e_full = 1'(fl);
      v.e_dpop = PCKG'(dpop);
      v.e_ovf  = 1'(ovf);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      wr_en = 0; pop = 0; push = 0; rd_en = 0; ovf_clr = 0;
      D_in = '0; D_push = '0;
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".tx_cnt"}, 32'(tx_cnt), 0);
      check({tag, ".rx_cnt"}, 32'(rx_cnt), 0);
      check({tag, ".pndng"}, 32'(pndng), 0);
      check({tag, ".rx_pndng"}, 32'(rx_pndng), 0);
      check({tag, ".full"}, 32'(full), 0);
      check({tag, ".tx_ovf"}, 32'(tx_ovf), 0);
      check({tag, ".rx_ovf"}, 32'(rx_ovf), 0);
      check({tag, ".D_pop"}, 32'(D_pop), 0);
      check({tag, ".D_out"}, 32'(D_out), 0);
   endtask

   // Reference model state
   logic [PCKG-1:0] txq[$];
   logic [PCKG-1:0] rxq[$];
   logic            m_tx_ovf, m_rx_ovf;

   initial begin
      idle();
      reset = 1'b1;
      #1;
      check_all_zero("reset0");
      step();
      step();
      reset = 1'b0;

      // ---- TX vector table ----
      for (int i = 0; i < 8; i++) add(1, 23 + i, 0, 0, i + 1, 1, (i == 7) ? 1 : 0, 23, 0);
      add(1, 99, 0, 0, 8, 1, 1, 23, 1);          // dropped write
      add(0, 0, 0, 1, 8, 1, 1, 23, 0);           // clear
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8 - k, (k < 8) ? 1 : 0, 0, (k < 8) ? 23 + k : 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);            // pop on empty ignored
      for (int i = 0; i < 8; i++) add(1, 23 + i, 0, 0, i + 1, 1, (i == 7) ? 1 : 0, 23, 0);
      add(1, 77, 0, 1, 8, 1, 1, 23, 1);          // overflow beats clear
      add(0, 0, 0, 1, 8, 1, 1, 23, 0);
      add(1, 40, 1, 0, 8, 1, 1, 24, 0);          // write+pop when full
      for (int k = 1; k <= 7; k++) add(0, 0, 1, 0, 8 - k, 1, 0, (k <= 6) ? 24 + k : 40, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 5, 1, 0, 1, 1, 0, 5, 0);            // write+pop when empty
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         idle();
         wr_en = vecs[i].wr; D_in = vecs[i].din; pop = vecs[i].pop; ovf_clr = vecs[i].clr;
         step();
         check($sformatf("vec%0d.tx_cnt", i), 32'(tx_cnt), 32'(vecs[i].e_cnt));
         check($sformatf("vec%0d.pndng", i), 32'(pndng), 32'(vecs[i].e_pnd));
         check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
         check($sformatf("vec%0d.D_pop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
         check($sformatf("vec%0d.tx_ovf", i), 32'(tx_ovf), 32'(vecs[i].e_ovf));
      end
      idle();

      // ---- RX: push 0..9, two dropped, drain 0..7 ----
      for (int i = 0; i < 10; i++) begin
         push = 1'b1; D_push = PCKG'(i);
         step();
      end
      idle();
      check("rx_fill.rx_cnt", 32'(rx_cnt), 8);
      check("rx_fill.rx_ovf", 32'(rx_ovf), 1);
      check("rx_fill.full_tx_unaffected", 32'(full), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rx_drain%0d.D_out", i), 32'(D_out), 32'(i));
         rd_en = 1'b1;
         step();
      end
      idle();
      check("rx_drain.rx_pndng", 32'(rx_pndng), 0);
      check("rx_drain.D_out", 32'(D_out), 0);
      ovf_clr = 1'b1;
      step();
      idle();
      check("rx_clr.rx_ovf", 32'(rx_ovf), 0);

      // ---- Mid-stream asynchronous reset ----
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; D_in = PCKG'(i + 1);
         push = (i < 2); D_push = PCKG'(i + 7);
         step();
      end
      idle();
      check("pre_rst.tx_cnt", 32'(tx_cnt), 3);
      check("pre_rst.rx_cnt", 32'(rx_cnt), 2);
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      wr_en = 1'b1; push = 1'b1; pop = 1'b1; rd_en = 1'b1; ovf_clr = 1'b1;
      D_in = 16'h1234; D_push = 16'h4321;
      step();
      step();
      check_all_zero("rst_held");
      idle();
      reset = 1'b0;
      wr_en = 1'b1; D_in = 16'h0055;
      step();
      idle();
      check("post_rst.pndng", 32'(pndng), 1);
      check("post_rst.D_pop", 32'(D_pop), 32'h55);
      check("post_rst.tx_cnt", 32'(tx_cnt), 1);
      check("post_rst.rx_cnt", 32'(rx_cnt), 0);

      // ---- Randomized run against queue model ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      txq.delete(); rxq.delete();
      m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         int bias;
         bit tx_w, tx_r, rx_w, rx_r;
         bias    = ((c / 125) % 2 == 0) ? 70 : 30;
         wr_en   = ($urandom_range(0, 99) < bias);
         pop     = ($urandom_range(0, 99) < 100 - bias);
         push    = ($urandom_range(0, 99) < bias);
         rd_en   = ($urandom_range(0, 99) < 100 - bias);
         ovf_clr = ($urandom_range(0, 15) == 0);
         D_in    = PCKG'($urandom);
         D_push  = PCKG'($urandom);

         tx_r = pop && (txq.size() > 0);
         tx_w = wr_en && (txq.size() < DEPTH || tx_r);
         rx_r = rd_en && (rxq.size() > 0);
         rx_w = push && (rxq.size() < DEPTH || rx_r);
         if (ovf_clr) begin m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; end
         if (wr_en && !tx_w) m_tx_ovf = 1'b1;
         if (push && !rx_w) m_rx_ovf = 1'b1;
         if (tx_r) void'(txq.pop_front());
         if (tx_w) txq.push_back(D_in);
         if (rx_r) void'(rxq.pop_front());
         if (rx_w) rxq.push_back(D_push);

         step();
         check($sformatf("rnd%0d.tx_cnt", c), 32'(tx_cnt), 32'(txq.size()));
         check($sformatf("rnd%0d.full", c), 32'(full), 32'(txq.size() == DEPTH));
         check($sformatf("rnd%0d.pndng", c), 32'(pndng), 32'(txq.size() != 0));
         check($sformatf("rnd%0d.D_pop", c), 32'(D_pop), (txq.size() != 0) ? 32'(txq[0]) : 0);
         check($sformatf("rnd%0d.tx_ovf", c), 32'(tx_ovf), 32'(m_tx_ovf));
         check($sformatf("rnd%0d.rx_cnt", c), 32'(rx_cnt), 32'(rxq.size()));
         check($sformatf("rnd%0d.rx_pndng", c), 32'(rx_pndng), 32'(rxq.size() != 0));
         check($sformatf("rnd%0d.D_out", c), 32'(D_out), (rxq.size() != 0) ? 32'(rxq[0]) : 0);
         check($sformatf("rnd%0d.rx_ovf", c), 32'(rx_ovf), 32'(m_rx_ovf));
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
